// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO console responder: register offsets,
// STATUS bit positions and the byte-lane merge used by writable registers.
package mmio_pkg;

  typedef enum logic [1:0] {
    OFF_HALT   = 2'd0,
    OFF_TXDATA = 2'd1,
    OFF_STATUS = 2'd2,
    OFF_CYCLE  = 2'd3
  } reg_off_e;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_HALT      = 3;
  localparam int ST_COUNT_LSB = 8;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Synchronous FIFO for console bytes. A push into a full FIFO is still
// accepted when a pop frees an entry in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             accept
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  assign dout   = mem[rd_ptr];

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the adder.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_console.sv
// MMIO responder for the simulation harness: halt/result latch, console TX
// FIFO drained over valid/ready, status word and a free-running cycle counter.
module mmio_console
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'hFFFFFFF0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] halt_code
);

  logic             sel;
  reg_off_e         off;
  logic             wr;
  logic             halt_valid;
  logic             overflow;
  logic [31:0]      cycle;
  logic             push;
  logic             accept;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [31:0]      status;
  logic             unused_addr_lsbs;

  assign sel              = (bus_address[31:4] == BASE[31:4]);
  assign off              = reg_off_e'(bus_address[3:2]);
  assign wr               = bus_write_enable && sel;
  assign push             = wr && (off == OFF_TXDATA) && bus_byte_enable[0];
  assign unused_addr_lsbs = ^bus_address[1:0];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (tx_valid && tx_ready),
    .din    (bus_write_data[7:0]),
    .dout   (tx_data),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .accept (accept)
  );

  assign tx_valid = !empty;
  assign done     = halt_valid && empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      halt_valid <= 1'b0;
      halt_code  <= '0;
      overflow   <= 1'b0;
      cycle      <= '0;
    end else begin
      if (wr && (off == OFF_HALT)) begin
        halt_valid <= 1'b1;
        halt_code  <= be_merge(halt_code, bus_write_data, bus_byte_enable);
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end else if (wr && (off == OFF_STATUS) && bus_write_data[ST_OVF]) begin
        overflow <= 1'b0;
      end
      // A software write to CYCLE takes the place of that cycle's increment.
      if (wr && (off == OFF_CYCLE)) begin
        cycle <= be_merge(cycle, bus_write_data, bus_byte_enable);
      end else begin
        cycle <= cycle + 32'd1;
      end
    end
  end

  always_comb begin
    status                       = '0;
    status[ST_EMPTY]             = empty;
    status[ST_FULL]              = full;
    status[ST_OVF]               = overflow;
    status[ST_HALT]              = halt_valid;
    status[ST_COUNT_LSB +: 8]    = 8'(count);
  end

  always_comb begin
    bus_read_data = '0;
    if (bus_read_enable && sel) begin
      case (off)
        OFF_HALT:   bus_read_data = halt_code;
        OFF_TXDATA: bus_read_data = '0;
        OFF_STATUS: bus_read_data = status;
        OFF_CYCLE:  bus_read_data = cycle;
        default:    bus_read_data = '0;
      endcase
    end
  end

endmodule
